// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one address-rotate stage among four ports.
// Four-phase req/ack on both sides; all outputs registered.
module shift_arbiter #(
  parameter int WIDTH = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         in_req,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ack,
  output logic               out_req,
  output logic [WIDTH-1:0]   out_data,
  input  logic               out_ack,
  output logic [3:0]         grant,
  output logic               busy,
  output logic [7:0]         pkt_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] RETN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [3:0]       in_ack_q, in_ack_d;
  logic             out_req_q, out_req_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       last_q, last_d;
  logic [7:0]       pkt_count_q, pkt_count_d;

  logic       win_hit;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic [1:0] g_idx;

  // Scan last+1, last+2, ... so the most recently served port goes last
  always_comb begin
    win_hit = 1'b0;
    win_idx = 2'd0;
    cand    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!win_hit && in_req[cand]) begin
        win_hit = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    g_idx = 2'd0;
    unique case (1'b1)
      grant_q[0]: g_idx = 2'd0;
      grant_q[1]: g_idx = 2'd1;
      grant_q[2]: g_idx = 2'd2;
      grant_q[3]: g_idx = 2'd3;
      default:    g_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    in_ack_d    = in_ack_q;
    out_req_d   = out_req_q;
    out_data_d  = out_data_q;
    last_d      = last_q;
    pkt_count_d = pkt_count_q;
    unique case (state_q)
      IDLE: begin
        if (win_hit) begin
          grant_d    = 4'b0001 << win_idx;
          out_data_d = in_data[win_idx*WIDTH +: WIDTH];
          out_req_d  = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (out_ack) begin
          out_req_d = 1'b0;
          in_ack_d  = grant_q;
          state_d   = RETN;
        end
      end
      RETN: begin
        if (!out_ack && ((in_req & grant_q) == 4'b0000)) begin
          in_ack_d    = 4'b0000;
          grant_d     = 4'b0000;
          last_d      = g_idx;
          pkt_count_d = pkt_count_q + 8'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= 4'b0000;
      in_ack_q    <= 4'b0000;
      out_req_q   <= 1'b0;
      out_data_q  <= '0;
      last_q      <= 2'd3;
      pkt_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      in_ack_q    <= in_ack_d;
      out_req_q   <= out_req_d;
      out_data_q  <= out_data_d;
      last_q      <= last_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign in_ack    = in_ack_q;
  assign out_req   = out_req_q;
  assign out_data  = out_data_q;
  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: stimulus queues expected grants,
// a negedge monitor pops them as out_req rises.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_req;
  logic [43:0] in_data;
  logic [3:0]  in_ack;
  logic        out_req;
  logic [10:0] out_data;
  logic        out_ack;
  logic [3:0]  grant;
  logic        busy;
  logic [7:0]  pkt_count;

  logic        auto_mode;
  logic [3:0]  want;
  logic [3:0]  man_req;
  logic        man_ack;

  int n_cmp = 0;
  int n_err = 0;

  logic [14:0] sbq[$];
  logic [14:0] cur;
  logic        mon_prev;

  always #5 clk = ~clk;

  assign in_req  = auto_mode ? (want & ~in_ack) : man_req;
  assign out_ack = auto_mode ? out_req : man_ack;

  shift_arbiter #(.WIDTH(11)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_req   (in_req),
    .in_data  (in_data),
    .in_ack   (in_ack),
    .out_req  (out_req),
    .out_data (out_data),
    .out_ack  (out_ack),
    .grant    (grant),
    .busy     (busy),
    .pkt_count(pkt_count)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_data(input int p, input logic [10:0] v);
    in_data[p*11 +: 11] = v;
  endtask

  task automatic push(input logic [3:0] g, input logic [10:0] d);
    sbq.push_back({g, d});
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    auto_mode = 1'b0;
    want      = 4'b0;
    man_req   = 4'b0;
    man_ack   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 10 && !out_req; i++) tick();
    chk("wait_out_req", out_req, 1);
  endtask

  task automatic serve(input logic [3:0] g);
    wait_req();
    chk("srv_grant", grant, g);
    man_ack = 1'b1;
    tick();
    chk("srv_ack", in_ack, g);
    chk("srv_req_low", out_req, 0);
    man_ack = 1'b0;
    man_req = man_req & ~g;
    tick();
    chk("srv_release", in_ack, 0);
  endtask

  always @(negedge clk) begin
    chk("excl", {31'b0, out_req & (|in_ack)}, 0);
    if (out_req && !mon_prev) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_grant: got %b want none", grant);
      end else begin
        cur = sbq.pop_front();
        chk("mon_grant", grant, cur[14:11]);
        chk("mon_data", out_data, cur[10:0]);
      end
    end else if (out_req) begin
      chk("mon_hold", out_data, cur[10:0]);
    end
    mon_prev = out_req;
  end

  initial begin
    mon_prev = 1'b0;
    cur      = '0;
    in_data  = '0;
    do_reset();

    // reset state
    chk("rst_in_ack", in_ack, 0);
    chk("rst_out_req", out_req, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt", pkt_count, 0);

    // single port
    set_data(0, 11'b01010100111);
    push(4'b0001, 11'b01010100111);
    man_req = 4'b0001;
    chk("sp_req_pre", out_req, 0);
    tick();
    chk("sp_req_lat", out_req, 1);
    chk("sp_busy", busy, 1);
    man_ack = 1'b1;
    tick();
    chk("sp_ack", in_ack, 4'b0001);
    chk("sp_req_fall", out_req, 0);
    man_ack = 1'b0;
    man_req = 4'b0;
    tick();
    chk("sp_rel", in_ack, 0);
    chk("sp_grant0", grant, 0);
    chk("sp_pkt", pkt_count, 1);

    // round robin, zero-delay partners
    do_reset();
    set_data(0, 11'h0A1);
    set_data(1, 11'h1B2);
    set_data(2, 11'h2C3);
    set_data(3, 11'h3D4);
    push(4'b0001, 11'h0A1);
    push(4'b0010, 11'h1B2);
    push(4'b0100, 11'h2C3);
    push(4'b1000, 11'h3D4);
    push(4'b0001, 11'h0A1);
    want      = 4'b1111;
    auto_mode = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    chk("rr_pkt11", pkt_count, 3);
    tick();
    chk("rr_pkt12", pkt_count, 4);
    tick();
    chk("rr_fifth", grant, 4'b0001);
    want = 4'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("rr_pkt_end", pkt_count, 5);
    chk("rr_idle", busy, 0);
    auto_mode = 1'b0;

    // fairness: serve port 1 so last=1, then 0 and 3 together
    set_data(1, 11'h155);
    push(4'b0010, 11'h155);
    man_req = 4'b0010;
    serve(4'b0010);
    set_data(0, 11'h011);
    set_data(3, 11'h733);
    push(4'b1000, 11'h733);
    push(4'b0001, 11'h011);
    man_req = 4'b1001;
    tick();
    serve(4'b1000);
    serve(4'b0001);

    // data hold, early req drop
    set_data(2, 11'b11011100100);
    push(4'b0100, 11'b11011100100);
    man_req = 4'b0100;
    tick();
    chk("dh_req", out_req, 1);
    set_data(2, 11'd0);
    man_req = 4'b0;
    tick();
    tick();
    chk("dh_still_req", out_req, 1);
    chk("dh_data", out_data, 11'b11011100100);
    man_ack = 1'b1;
    tick();
    chk("dh_ack", in_ack, 4'b0100);
    man_ack = 1'b0;
    tick();
    chk("dh_rel", in_ack, 0);
    chk("dh_pkt", pkt_count, 9);

    // release ordering A: req falls first, ack held 5 more clocks
    set_data(1, 11'h222);
    set_data(0, 11'h0F0);
    push(4'b0010, 11'h222);
    man_req = 4'b0010;
    wait_req();
    man_ack = 1'b1;
    tick();
    chk("roA_ack", in_ack, 4'b0010);
    man_req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("roA_hold_ack", in_ack, 4'b0010);
      chk("roA_no_grant", grant, 4'b0010);
    end
    push(4'b0001, 11'h0F0);
    man_ack = 1'b0;
    tick();
    chk("roA_rel", in_ack, 0);
    chk("roA_idle", busy, 0);
    serve(4'b0001);

    // release ordering B: ack falls first, req held 5 more clocks
    set_data(2, 11'h444);
    push(4'b0100, 11'h444);
    man_req = 4'b0100;
    wait_req();
    man_ack = 1'b1;
    tick();
    chk("roB_ack", in_ack, 4'b0100);
    man_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("roB_hold_ack", in_ack, 4'b0100);
      chk("roB_busy", busy, 1);
    end
    man_req = 4'b0;
    tick();
    chk("roB_rel", in_ack, 0);
    chk("roB_pkt", pkt_count, 12);

    // reset mid-operation during RETURN
    set_data(1, 11'h3A5);
    push(4'b0010, 11'h3A5);
    man_req = 4'b0010;
    wait_req();
    man_ack = 1'b1;
    tick();
    chk("rm_ack", in_ack, 4'b0010);
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    man_ack = 1'b0;
    man_req = 4'b0;
    chk("rm_in_ack", in_ack, 0);
    chk("rm_out_req", out_req, 0);
    chk("rm_out_data", out_data, 0);
    chk("rm_grant", grant, 0);
    chk("rm_busy", busy, 0);
    chk("rm_pkt", pkt_count, 0);
    set_data(0, 11'h101);
    push(4'b0001, 11'h101);
    push(4'b0010, 11'h3A5);
    man_req = 4'b0011;
    tick();
    serve(4'b0001);
    serve(4'b0010);

    // counter wrap
    do_reset();
    set_data(0, 11'h2AB);
    for (int i = 0; i < 256; i++) push(4'b0001, 11'h2AB);
    want      = 4'b0001;
    auto_mode = 1'b1;
    for (int i = 0; i < 765; i++) tick();
    chk("wrap_255", pkt_count, 255);
    for (int i = 0; i < 3; i++) tick();
    chk("wrap_0", pkt_count, 0);
    want = 4'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("wrap_idle", busy, 0);
    chk("wrap_pkt_stay", pkt_count, 0);
    auto_mode = 1'b0;

    tick();
    chk("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

- Clocked round-robin arbiter that shares the router's single left-shift (address-rotate) stage between four input ports.
- Each input port offers an 11-bit packet on a four-phase req/ack channel. The arbiter grants one port at a time, latches its packet, and forwards it on one downstream four-phase channel that feeds the shift stage.
- It completes the return-to-zero phase on both sides before serving the next port.

## Interface
- WIDTH, 11, packet width in bits.
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_req  input  4  request from input port i (bit i), four-phase.
- in_data  input  4*WIDTH  packet of port i in bits [i*WIDTH +: WIDTH]; stable while in_req[i]=1.
- in_ack  output  4  acknowledge to port i; one-hot or zero.
- out_req  output  1  request to the shift stage.
- out_data  output  WIDTH  registered packet to the shift stage; stable while out_req=1.
- out_ack  input  1  acknowledge from the shift stage.
- grant  output  4  one-hot index of the port currently being served; 0 in IDLE.
- busy  output  1  1 in any state other than IDLE.
- pkt_count  output  8  number of packets completed; wraps 255 -> 0.

## Operation
- FSM states are IDLE, SEND and RETURN. Reset loads IDLE.
- Reset values:
  - in_ack=0, out_req=0, out_data=0, grant=0, busy=0, pkt_count=0.
  - Last-served pointer last=3, so port 0 has top priority first.
- IDLE: if any in_req bit is 1, the winner is the first requesting port scanning last+1, last+2, ... mod 4. On that edge:
  - grant gets the winner one-hot;
  - out_data gets the winner's in_data slice;
  - out_req goes to 1;
  - the FSM moves to SEND.
  - If no in_req bit is 1, the FSM stays in IDLE.
- SEND: on the edge where out_ack=1:
  - out_req goes to 0 and in_ack[g] goes to 1 in the same edge;
  - the FSM moves to RETURN.
- RETURN: waits until both out_ack=0 and in_req[g]=0 are sampled on the same edge; either may fall first. On that edge:
  - in_ack goes to 0 and grant goes to 0;
  - last is set to g;
  - pkt_count increments;
  - the FSM moves to IDLE.
- Data is captured only at grant. Later changes on in_data[g], or an early drop of in_req[g] in SEND, have no effect on out_data. An early drop in SEND does not abort the transfer.
- A non-granted port may raise or withdraw in_req at any time; withdrawal in IDLE before grant is legal.
- Requests arriving while busy wait. They are considered only on an edge where the FSM is in IDLE.
- reset=1 in any state forces the reset values on the next edge, and the in-flight packet is discarded. Both the shift stage and the requesters must also be reset.

## Timing
- Grant latency: in_req sampled at edge k in IDLE gives out_req=1 and out_data valid after edge k.
- Forward latency: out_ack sampled high at edge m gives out_req=0 and in_ack[g]=1 after edge m.
- Release: the RETURN condition met at edge p gives in_ack=0 and IDLE after edge p. The next grant is earliest at edge p+1.
- Minimum cycle per packet with zero-delay partners is 3 clocks, giving 4 packets in 12 clocks under continuous requests.
- out_req and in_ack[g] are never simultaneously 1.
- No combinational path exists from any input to any output; all outputs are registered.

## Test plan
- Single port: reset, then port 0 sends 11'b01010100111.
  - Required: out_data=11'b01010100111, out_req rises 1 clock after in_req[0].
  - Required: in_ack[0] rises the clock after out_ack.
  - Required: pkt_count=1 after the return to zero.
- Round robin: all four ports request continuously with data 0x0A1, 0x1B2, 0x2C3, 0x3D4, and the shift stage responds in 0 cycles.
  - Required: grant sequence 0001, 0010, 0100, 1000, 0001.
  - Required: 3 clocks per packet and pkt_count=4 at clock 12.
- Fairness after last=1: ports 0 and 3 request simultaneously.
  - Required: port 3 is granted first, then port 0.
- Data hold: port 2 sends 11'b11011100100, then changes in_data to 0 and drops in_req while in SEND.
  - Required: out_data stays 11'b11011100100 until out_req falls, and in_ack[2] still pulses.
- Release ordering: out_ack falls 5 clocks after in_req[g] falls, and vice versa in a second run.
  - Required: in_ack falls only on the edge after both are low, and there is no early new grant.
- Reset mid-operation: assert reset during RETURN with in_ack[1]=1.
  - Required: all outputs are 0 the next clock and the FSM is in IDLE.
  - Required: the next request from ports 1 and 0 together grants port 0.
- Counter wrap: 256 packets.
  - Required: pkt_count returns to 0.
